spy_fifo_reader: RTL and testbench
==================================

Name: spy_fifo_reader

Overview:
Drain engine on the pop side of the spy capture FIFO. It pops one DATA_WIDTH capture record whenever the FIFO is non-empty and the engine is free. It serialises the record into OUT_WIDTH beats on a valid/ready stream towards the trace export path. It is the reader counterpart to the push-side capture logic.

Parameters:
DATA_WIDTH, 64, width of one FIFO record; must equal the FIFO's DATA_WIDTH.
OUT_WIDTH, 16, width of one output beat; DATA_WIDTH must be an integer multiple of OUT_WIDTH (elaboration error otherwise).
CNT_W, 16, width of the records-sent counter.

Ports:
clk  in  1  clock, all flops on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
enable_i  in  1  allows new pops; deassertion never truncates a record in flight
fifo_empty_i  in  1  FIFO empty flag
fifo_pop_o  out  1  pop strobe to FIFO, one cycle per record
fifo_pop_data_i  in  DATA_WIDTH  FIFO head data, valid in the same cycle as fifo_pop_o
m_valid_o  out  1  output beat valid
m_ready_i  in  1  downstream accepts beat
m_data_o  out  OUT_WIDTH  output beat data
m_last_o  out  1  final beat of current record
busy_o  out  1  record held (state ST_SEND)
sent_cnt_o  out  CNT_W  records fully transmitted since reset, wraps modulo 2^CNT_W

Behaviour:
- BEATS = DATA_WIDTH/OUT_WIDTH. Beat index counter has width $clog2(BEATS), with a minimum of 1 bit.
- Reset (reset==0, asynchronous): state=ST_IDLE; hold register=0; beat index=0; m_valid_o=0; m_last_o=0; m_data_o=0; sent_cnt_o=0; busy_o=0. fifo_pop_o is forced 0 while reset is asserted.
- Reset mid-record: the held record is discarded and is not re-popped. The FIFO is reset by the same net.
- Pop condition, combinational:
  - pop_ok = enable_i & ~fifo_empty_i & (state==ST_IDLE | (state==ST_SEND & last_accept)).
  - last_accept = m_valid_o & m_ready_i & m_last_o.
  - fifo_pop_o = pop_ok.
  - fifo_pop_data_i is sampled into the hold register on the same edge.
- FSM:
  - ST_IDLE: m_valid_o=0. On pop_ok: capture record, beat index=0, go to ST_SEND.
  - ST_SEND: m_valid_o=1; m_data_o=hold[idx*OUT_WIDTH +: OUT_WIDTH], LSB slice first; m_last_o=(idx==BEATS-1).
  - ST_SEND, on accept of a non-last beat: idx+1.
  - ST_SEND, on last_accept: sent_cnt_o+1. Then if pop_ok, capture the next record, idx=0, stay in ST_SEND (back-to-back, no bubble). Otherwise go to ST_IDLE.
- Latency: first beat valid 1 cycle after the pop edge. Steady-state throughput is 1 beat/cycle with m_ready_i held high; BEATS cycles per record, no gap between records.
- Stall: while m_valid_o & ~m_ready_i, m_data_o, m_last_o and idx are held stable, and no pop occurs.
- m_valid_o, m_data_o and m_last_o are registered, or decoded purely from registered state; there is no combinational path from m_ready_i to m_valid_o.
- enable_i low: no new pops. A record in ST_SEND completes all beats. enable_i is not sampled mid-record.
- BEATS==1: every beat has m_last_o=1, and a pop may coincide with every accept.
- fifo_empty_i is never violated: fifo_pop_o is never asserted while fifo_empty_i==1.
- busy_o = (state==ST_SEND).

Decomposition:
- Shared package spy_pkg holds:
  - state_t enum {ST_IDLE, ST_SEND};
  - the default widths, SPY_REC_W=64 and SPY_OUT_W=16.
- Single module, no sub-module. The beat slice mux is an inline indexed part-select.

Test Plan:
1. Reset low, then high, with the FIFO empty -> fifo_pop_o=0, m_valid_o=0, sent_cnt_o=0 for 10 cycles.
2. Push 64'h0123_4567_89AB_CDEF, m_ready_i=1 -> one pop; beats 16'hCDEF, 16'h89AB, 16'h4567, 16'h0123 on consecutive cycles; m_last_o on the 4th beat only; sent_cnt_o=1.
3. Three records queued, m_ready_i=1 -> 12 contiguous valid beats; pops occur exactly in the cycles of beats 4 and 8 (the last-beat accepts); sent_cnt_o=3.
4. m_ready_i low for 5 cycles during beat 2 -> m_data_o held at 16'h89AB for all stalled cycles; no pop; the stream then resumes.
5. enable_i dropped during beat 1 with 2 records queued -> the current record finishes all 4 beats; no further pop until enable_i rises.
6. reset asserted during beat 3 -> m_valid_o=0 immediately (asynchronous); sent_cnt_o=0; the bench confirms the next record after reset starts at beat 0.

Source files
------------

// File: rtl/spy_pkg.sv
// Shared types and default widths for the spy capture path.
// Used by the FIFO push side and the drain engine.
package spy_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    localparam int SPY_REC_W = 64;
    localparam int SPY_OUT_W = 16;

endpackage

// File: rtl/spy_fifo_reader.sv
// Spy FIFO drain engine: pops capture records and serialises them
// into OUT_WIDTH beats on a valid/ready stream, LSB slice first.
module spy_fifo_reader
    import spy_pkg::*;
#(
    parameter int DATA_WIDTH = SPY_REC_W,
    parameter int OUT_WIDTH  = SPY_OUT_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_pop_o,
    input  logic [DATA_WIDTH-1:0] fifo_pop_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [OUT_WIDTH-1:0]  m_data_o,
    output logic                  m_last_o,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      sent_cnt_o
);

    localparam int BEATS = DATA_WIDTH / OUT_WIDTH;
    localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);

    generate
        if ((DATA_WIDTH % OUT_WIDTH) != 0 || DATA_WIDTH < OUT_WIDTH) begin : g_bad_width
            $error("spy_fifo_reader: DATA_WIDTH must be a multiple of OUT_WIDTH");
        end
    endgenerate

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic send;
    logic accept;
    logic last_accept;
    logic pop_ok;

    assign send        = (state_q == ST_SEND);
    assign m_valid_o   = send;
    assign m_last_o    = send && (idx_q == LAST_IDX);
    assign m_data_o    = send ? hold_q[int'(idx_q)*OUT_WIDTH +: OUT_WIDTH] : '0;
    assign busy_o      = send;
    assign sent_cnt_o  = cnt_q;

    assign accept      = m_valid_o & m_ready_i;
    assign last_accept = accept & m_last_o;
    assign pop_ok      = enable_i & ~fifo_empty_i & (~send | last_accept);

    // Reset also gates the strobe so the FIFO is never popped under reset.
    assign fifo_pop_o  = pop_ok & reset;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pop_ok) begin
                    state_d = ST_SEND;
                    hold_d  = fifo_pop_data_i;
                    idx_d   = '0;
                end
            end
            ST_SEND: begin
                if (last_accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (pop_ok) begin
                        hold_d = fifo_pop_data_i;
                        idx_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (accept) begin
                    idx_d = idx_q + IW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_spy_fifo_reader.sv
// Directed self-checking bench for spy_fifo_reader with a small
// array-backed FIFO model on the pop side.
module tb_spy_fifo_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [63:0] fifo_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_last;
    logic        busy;
    logic [15:0] sent_cnt;

    logic [63:0] mem [16];
    int          rd = 0;
    int          wr = 0;

    int tests  = 0;
    int failed = 0;

    logic [15:0] beat_exp [4];
    logic [3:0]  hi_exp [3];

    always #5 clk = ~clk;

    assign fifo_empty = (rd == wr);
    assign fifo_data  = mem[rd[3:0]];

    always @(posedge clk) begin
        if (fifo_pop) rd <= rd + 1;
    end

    spy_fifo_reader #(
        .DATA_WIDTH(64),
        .OUT_WIDTH (16),
        .CNT_W     (16)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .enable_i       (enable),
        .fifo_empty_i   (fifo_empty),
        .fifo_pop_o     (fifo_pop),
        .fifo_pop_data_i(fifo_data),
        .m_valid_o      (m_valid),
        .m_ready_i      (m_ready),
        .m_data_o       (m_data),
        .m_last_o       (m_last),
        .busy_o         (busy),
        .sent_cnt_o     (sent_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] d);
        mem[wr[3:0]] = d;
        wr = wr + 1;
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        step();
        step();
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_last", m_last, 0);
        chk("rst_cnt", sent_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pop", fifo_pop, 0);

        // Test 1: idle with an empty FIFO
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t1_pop", fifo_pop, 0);
            chk("t1_valid", m_valid, 0);
            chk("t1_cnt", sent_cnt, 0);
        end

        // Test 2: single record
        beat_exp[0] = 16'hCDEF;
        beat_exp[1] = 16'h89AB;
        beat_exp[2] = 16'h4567;
        beat_exp[3] = 16'h0123;
        @(negedge clk);
        push(64'h0123_4567_89AB_CDEF);
        #1;
        chk("t2_pop", fifo_pop, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_valid", m_valid, 1);
            chk("t2_data", m_data, beat_exp[i]);
            chk("t2_last", m_last, (i == 3));
            chk("t2_pop_mid", fifo_pop, 0);
        end
        step();
        chk("t2_idle", m_valid, 0);
        chk("t2_cnt", sent_cnt, 1);

        // Test 3: three back-to-back records
        hi_exp[0] = 4'hA;
        hi_exp[1] = 4'hB;
        hi_exp[2] = 4'hC;
        @(negedge clk);
        push(64'hA003_A002_A001_A000);
        push(64'hB003_B002_B001_B000);
        push(64'hC003_C002_C001_C000);
        #1;
        chk("t3_pop0", fifo_pop, 1);
        for (int k = 0; k < 12; k++) begin
            step();
            chk("t3_valid", m_valid, 1);
            chk("t3_data", m_data, {hi_exp[k/4], 12'(k % 4)});
            chk("t3_last", m_last, ((k % 4) == 3));
            chk("t3_pop", fifo_pop, (k == 3 || k == 7));
        end
        step();
        chk("t3_idle", m_valid, 0);
        chk("t3_cnt", sent_cnt, 4);

        // Test 4: stall on beat 2
        @(negedge clk);
        push(64'h0123_4567_89AB_CDEF);
        #1;
        chk("t4_pop", fifo_pop, 1);
        step();
        chk("t4_b0", m_data, 16'hCDEF);
        step();
        chk("t4_b1", m_data, 16'h89AB);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_stall_valid", m_valid, 1);
            chk("t4_stall_data", m_data, 16'h89AB);
            chk("t4_stall_last", m_last, 0);
            chk("t4_stall_pop", fifo_pop, 0);
        end
        m_ready = 1'b1;
        step();
        chk("t4_b2", m_data, 16'h4567);
        step();
        chk("t4_b3", m_data, 16'h0123);
        chk("t4_b3_last", m_last, 1);
        step();
        chk("t4_idle", m_valid, 0);
        chk("t4_cnt", sent_cnt, 5);

        // Test 5: enable dropped during beat 1 with two records queued
        @(negedge clk);
        push(64'hD3D3_D2D2_D1D1_D0D0);
        push(64'hE3E3_E2E2_E1E1_E0E0);
        #1;
        chk("t5_pop", fifo_pop, 1);
        step();
        chk("t5_b0", m_data, 16'hD0D0);
        enable = 1'b0;
        #1;
        chk("t5_pop_dis", fifo_pop, 0);
        step();
        chk("t5_b1", m_data, 16'hD1D1);
        step();
        chk("t5_b2", m_data, 16'hD2D2);
        step();
        chk("t5_b3", m_data, 16'hD3D3);
        chk("t5_b3_last", m_last, 1);
        chk("t5_b3_pop", fifo_pop, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_hold_valid", m_valid, 0);
            chk("t5_hold_pop", fifo_pop, 0);
            chk("t5_hold_busy", busy, 0);
        end
        chk("t5_cnt_d", sent_cnt, 6);
        @(negedge clk);
        enable = 1'b1;
        #1;
        chk("t5_pop_en", fifo_pop, 1);
        step();
        chk("t5_e0", m_data, 16'hE0E0);
        step();
        chk("t5_e1", m_data, 16'hE1E1);
        step();
        chk("t5_e2", m_data, 16'hE2E2);
        step();
        chk("t5_e3", m_data, 16'hE3E3);
        step();
        chk("t5_cnt_e", sent_cnt, 7);

        // Test 6: asynchronous reset in the middle of a record
        @(negedge clk);
        push(64'hF3F3_F2F2_F1F1_F0F0);
        #1;
        chk("t6_pop", fifo_pop, 1);
        step();
        chk("t6_b0", m_data, 16'hF0F0);
        push(64'h1111_2222_3333_4444);
        step();
        chk("t6_b1", m_data, 16'hF1F1);
        step();
        chk("t6_b2", m_data, 16'hF2F2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", m_valid, 0);
        chk("t6_rst_cnt", sent_cnt, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_pop", fifo_pop, 0);
        chk("t6_rst_data", m_data, 0);
        wr = rd;
        step();
        chk("t6_rst_hold", m_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6_empty_pop", fifo_pop, 0);
        @(negedge clk);
        push(64'h7777_6666_5555_4444);
        #1;
        chk("t6_pop2", fifo_pop, 1);
        step();
        chk("t6_n0", m_data, 16'h4444);
        step();
        chk("t6_n1", m_data, 16'h5555);
        step();
        chk("t6_n2", m_data, 16'h6666);
        step();
        chk("t6_n3", m_data, 16'h7777);
        chk("t6_n3_last", m_last, 1);
        step();
        chk("t6_idle", m_valid, 0);
        chk("t6_cnt", sent_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
